// File: rtl/column_renderer.sv
// column_renderer: walks every pixel of a latched column of square cells, one pixel per clock.
// Optional macro COLUMN_RENDERER_SKIP_EMPTY_EN: cells with code 00 take one blank cycle instead of being drawn.
`default_nettype none

module column_renderer #(
    parameter int NUM_CELLS    = 14,
    parameter int CELL_BITS    = 2,
    parameter int CELL_SIZE    = 8,
    parameter int X_WIDTH      = 8,
    parameter int Y_WIDTH      = 7,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [NUM_CELLS*CELL_BITS-1:0] column_data,
    input  logic [X_WIDTH-1:0]             x_origin,
    output logic [X_WIDTH-1:0]             x,
    output logic [Y_WIDTH-1:0]             y,
    output logic [COLOUR_WIDTH-1:0]        colour,
    output logic                           plot,
    output logic                           busy,
    output logic                           done
);

    localparam int PW = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int CW = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;
    localparam logic [PW-1:0] PX_MAX    = PW'(CELL_SIZE - 1);
    localparam logic [CW-1:0] CELL_LAST = CW'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                           state_q;
    logic [NUM_CELLS*CELL_BITS-1:0]   data_q;
    logic [X_WIDTH-1:0]               xorg_q;
    logic [PW-1:0]                    px_q, py_q;
    logic [CW-1:0]                    cell_q;
    logic [X_WIDTH-1:0]               x_q;
    logic [Y_WIDTH-1:0]               y_q;
    logic [COLOUR_WIDTH-1:0]          colour_q;
    logic                             plot_q, busy_q, done_q;

    logic [PW-1:0]                    px_d, py_d;
    logic [CW-1:0]                    cell_d;
    logic                             cell_end_d, last_d, skip_now_d, draw_d, plot0_d;
    logic [CELL_BITS-1:0]             code_d, code0_d;

    function automatic logic [CELL_BITS-1:0] cell_code(
        input logic [NUM_CELLS*CELL_BITS-1:0] data,
        input logic [CW-1:0]                  idx
    );
        return data[int'(idx)*CELL_BITS +: CELL_BITS];
    endfunction

    function automatic logic [COLOUR_WIDTH-1:0] palette(input logic [CELL_BITS-1:0] code);
        case (code)
            CELL_BITS'(1): return COLOUR_WIDTH'(3'b010);
            CELL_BITS'(2): return COLOUR_WIDTH'(3'b100);
            default:       return COLOUR_WIDTH'(3'b011);
        endcase
    endfunction

    always_comb begin
        px_d       = px_q + PW'(1);
        py_d       = py_q;
        cell_d     = cell_q;
        cell_end_d = 1'b0;
        code0_d    = column_data[CELL_BITS-1:0];
`ifdef COLUMN_RENDERER_SKIP_EMPTY_EN
        // An empty cell is only ever entered at px=py=0, so its one blank cycle ends it.
        skip_now_d = (cell_code(data_q, cell_q) == '0);
        plot0_d    = (code0_d != '0);
`else
        skip_now_d = 1'b0;
        plot0_d    = 1'b1;
`endif
        if (skip_now_d || (px_q == PX_MAX && py_q == PX_MAX)) begin
            px_d       = '0;
            py_d       = '0;
            cell_d     = cell_q + CW'(1);
            cell_end_d = 1'b1;
        end else if (px_q == PX_MAX) begin
            px_d = '0;
            py_d = py_q + PW'(1);
        end
        last_d = cell_end_d && (cell_q == CELL_LAST);
        code_d = cell_code(data_q, last_d ? cell_q : cell_d);
`ifdef COLUMN_RENDERER_SKIP_EMPTY_EN
        draw_d = (code_d != '0);
`else
        draw_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            xorg_q   <= '0;
            px_q     <= '0;
            py_q     <= '0;
            cell_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= DRAW;
                        data_q  <= column_data;
                        xorg_q  <= x_origin;
                        px_q    <= '0;
                        py_q    <= '0;
                        cell_q  <= '0;
                        busy_q  <= 1'b1;
                        plot_q  <= plot0_d;
                        if (plot0_d) begin
                            x_q      <= x_origin;
                            y_q      <= '0;
                            colour_q <= palette(code0_d);
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                    end
                end
                DRAW: begin
                    if (last_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        plot_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        px_q   <= px_d;
                        py_q   <= py_d;
                        cell_q <= cell_d;
                        plot_q <= draw_d;
                        // Outputs are computed one cycle ahead so they line up with plot.
                        if (draw_d) begin
                            x_q      <= xorg_q + X_WIDTH'(px_d);
                            y_q      <= Y_WIDTH'(int'(cell_d) * CELL_SIZE + int'(py_d));
                            colour_q <= palette(code_d);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    plot_q  <= 1'b0;
                end
            endcase
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_column_renderer.sv
// tb_column_renderer: table-driven render vectors plus hand sequences, pixels checked by a scoreboard queue.
`timescale 1ns/1ps
`default_nettype none

module tb_column_renderer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [27:0] column_data = '0;
    logic [7:0]  x_origin = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;

    column_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .column_data(column_data),
        .x_origin   (x_origin),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int plot_cnt = 0;
    int pix_idx = 0;
    logic [17:0] first_pix, last_pix, pix64;
    logic [17:0] sb[$];

    typedef struct {
        logic [27:0] cd;
        logic [7:0]  xo;
        bit          disturb;
        int          exp_plots;
        int          exp_draws;
        logic [17:0] exp_first;
        logic [17:0] exp_last;
        bit          chk64;
        logic [17:0] exp_p64;
    } vec_t;

    vec_t tbl[6];

    function automatic logic [17:0] px(input int xx, input int yy, input int cc);
        return {8'(xx), 7'(yy), 3'(cc)};
    endfunction

    function automatic logic [2:0] pal(input logic [1:0] code);
        case (code)
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b011;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_model(input logic [27:0] cd, input logic [7:0] xo);
        logic [1:0] code;
        logic [7:0] xx;
        for (int c = 0; c < 14; c++) begin
            code = cd[2*c +: 2];
`ifdef COLUMN_RENDERER_SKIP_EMPTY_EN
            if (code == 2'b00) continue;
`endif
            for (int r = 0; r < 8; r++)
                for (int p = 0; p < 8; p++) begin
                    xx = xo + 8'(p);
                    sb.push_back({xx, 7'(c*8 + r), pal(code)});
                end
        end
    endtask

    always @(negedge clk) begin
        if (plot) begin
            logic [17:0] e;
            plot_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0h, expected no plot", x, y, colour);
            end else begin
                e = sb.pop_front();
                check("pixel", {14'd0, x, y, colour}, {14'd0, e});
            end
            if (pix_idx == 0) first_pix = {x, y, colour};
            if (pix_idx == 64) pix64 = {x, y, colour};
            last_pix = {x, y, colour};
            pix_idx++;
        end
    end

    task automatic do_render(input logic [27:0] cd, input logic [7:0] xo, input bit disturb,
                             output int plots, output int draws, output bit got_done, output bit prev_busy);
        int p0;
        @(posedge clk); #1;
        column_data = cd;
        x_origin    = xo;
        start       = 1'b1;
        push_model(cd, xo);
        pix_idx  = 0;
        p0       = plot_cnt;
        draws    = 0;
        got_done = 1'b0;
        prev_busy = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            prev_busy = busy;
            if (busy) draws++;
            if (disturb) begin
                if (draws == 5) begin
                    column_data = 28'haaaaaaa;
                    x_origin    = xo + 8'd17;
                end
                if (draws == 10) start = 1'b1;
                if (draws == 11) start = 1'b0;
            end
        end
        plots = plot_cnt - p0;
    endtask

    initial begin
        int  plots, draws;
        bit  got_done, prev_busy;
        bit  idle_ok;

`ifdef COLUMN_RENDERER_SKIP_EMPTY_EN
        tbl[0] = '{28'h0000001, 8'd40, 1'b0, 64, 77, px(40,0,2), px(47,7,2), 1'b0, 18'd0};
        tbl[3] = '{28'h8000000, 8'd40, 1'b0, 64, 77, px(40,104,4), px(47,111,4), 1'b0, 18'd0};
        tbl[4] = '{28'h0000000, 8'd5, 1'b0, 0, 14, 18'd0, 18'd0, 1'b0, 18'd0};
        tbl[5] = '{28'h0000001, 8'd40, 1'b1, 64, 77, px(40,0,2), px(47,7,2), 1'b0, 18'd0};
`else
        tbl[0] = '{28'h0000001, 8'd40, 1'b0, 896, 896, px(40,0,2), px(47,111,3), 1'b1, px(40,8,3)};
        tbl[3] = '{28'h8000000, 8'd40, 1'b0, 896, 896, px(40,0,3), px(47,111,4), 1'b1, px(40,8,3)};
        tbl[4] = '{28'h0000000, 8'd5, 1'b0, 896, 896, px(5,0,3), px(12,111,3), 1'b1, px(5,8,3)};
        tbl[5] = '{28'h0000001, 8'd40, 1'b1, 896, 896, px(40,0,2), px(47,111,3), 1'b1, px(40,8,3)};
`endif
        tbl[1] = '{28'haaaaaaa, 8'd252, 1'b0, 896, 896, px(252,0,4), px(3,111,4), 1'b1, px(252,8,4)};
        tbl[2] = '{28'hfffffff, 8'd0, 1'b0, 896, 896, px(0,0,3), px(7,111,3), 1'b1, px(0,8,3)};

        repeat (3) @(negedge clk);
        check("reset_outputs", {12'd0, x, y, colour, plot, busy, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            do_render(tbl[v].cd, tbl[v].xo, tbl[v].disturb, plots, draws, got_done, prev_busy);
            check("done_seen", {31'd0, got_done}, 32'd1);
            check("done_after_draw", {31'd0, prev_busy}, 32'd1);
            check("plot_count", plots, tbl[v].exp_plots);
            check("draw_cycles", draws, tbl[v].exp_draws);
            check("done_busy_low", {30'd0, busy, plot}, 32'd0);
            check("sb_drained", sb.size(), 32'd0);
            if (tbl[v].exp_plots > 0) begin
                check("first_pixel", {14'd0, first_pix}, {14'd0, tbl[v].exp_first});
                check("last_pixel", {14'd0, last_pix}, {14'd0, tbl[v].exp_last});
            end
            if (tbl[v].chk64) check("pixel_64", {14'd0, pix64}, {14'd0, tbl[v].exp_p64});
            @(negedge clk);
            check("idle_after_done", {29'd0, done, busy, plot}, 32'd0);
            if (tbl[v].exp_plots > 0)
                check("outputs_hold", {14'd0, x, y, colour}, {14'd0, tbl[v].exp_last});
        end

        // Reset asserted in the middle of a render.
        @(posedge clk); #1;
        column_data = 28'haaaaaaa;
        x_origin    = 8'd10;
        start       = 1'b1;
        push_model(28'haaaaaaa, 8'd10);
        @(posedge clk); #1;
        start = 1'b0;
        draws = 0;
        for (int i = 0; i < 200 && draws < 100; i++) begin
            @(negedge clk);
            if (busy) draws++;
        end
        check("draws_before_reset", draws, 32'd100);
        #1 reset = 1'b0;
        #1 check("reset_mid_render", {12'd0, x, y, colour, plot, busy, done}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (plot || busy || done) idle_ok = 1'b0;
        end
        check("idle_after_reset", {31'd0, idle_ok}, 32'd1);

        // Start held high: the second render follows DONE with no IDLE cycle.
        @(posedge clk); #1;
        column_data = 28'h5555555;
        x_origin    = 8'd100;
        start       = 1'b1;
        push_model(28'h5555555, 8'd100);
        got_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        check("b2b_done1", {31'd0, got_done}, 32'd1);
        check("b2b_sb1", sb.size(), 32'd0);
        push_model(28'h5555555, 8'd100);
        @(negedge clk);
        check("b2b_restart", {30'd0, busy, plot}, 32'd3);
        start = 1'b0;
        got_done = 1'b0;
        draws = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) draws++;
        end
        check("b2b_done2", {31'd0, got_done}, 32'd1);
        check("b2b_draws2", draws, 32'd896);
        check("b2b_sb2", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/column_renderer.md
Name: column_renderer

Overview:
- Parametrised successor to the fixed 14-cell column drawer.
- On a start pulse, latches a packed column of 2-bit cell codes and an x origin, then walks every pixel of every square cell.
- Emits one pixel per clock (x, y, colour, plot) to the VGA adapter's write port.
- Sits between the game datapath (column registers, rate divider tick) and the VGA adapter; one instance per column or time-shared by the controller.

Parameters:
- NUM_CELLS, 14, number of cells in the column; cell 0 is topmost.
- CELL_BITS, 2, bits per cell code (fixed palette below assumes 2).
- CELL_SIZE, 8, cell edge length in pixels; must be a power of two.
- X_WIDTH, 8, width of the x coordinate.
- Y_WIDTH, 7, width of the y coordinate; NUM_CELLS*CELL_SIZE must not exceed 2**Y_WIDTH.
- COLOUR_WIDTH, 3, width of the colour output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to render; accepted only when busy=0.
- column_data  in  NUM_CELLS*CELL_BITS  packed cell codes; cell k occupies bits [k*CELL_BITS+1 : k*CELL_BITS].
- x_origin  in  X_WIDTH  left pixel column of the cells.
- x  out  X_WIDTH  pixel x.
- y  out  Y_WIDTH  pixel y.
- colour  out  COLOUR_WIDTH  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  render in progress.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Interface (already decided): one clock, clk. reset is asynchronous and active-low.
- Reset, asynchronous and active-low:
  - state=IDLE; pixel and cell counters, latched data and latched origin cleared.
  - x=0, y=0, colour=0, plot=0, busy=0, done=0.
  - Reset mid-render aborts immediately; no further plot.
- States: IDLE, DRAW, DONE.
- IDLE:
  - busy=0, plot=0.
  - start=1 latches column_data and x_origin, zeroes counters px, py, cell, and moves to DRAW.
- DRAW:
  - busy=1, plot=1; outputs are valid in the same cycle.
  - x = x_origin_latched + px, truncated to X_WIDTH, so it wraps modulo 2**X_WIDTH.
  - y = cell*CELL_SIZE + py.
  - Scan order: px increments fastest, then py, then cell.
  - After px=py=CELL_SIZE-1 in cell NUM_CELLS-1, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, plot=0.
  - start=1 in this cycle is accepted, same as in IDLE, and goes straight back to DRAW. Otherwise go to IDLE.
- Latency: first plot in the cycle after start is sampled. Total plot cycles = NUM_CELLS*CELL_SIZE*CELL_SIZE (896 at defaults). done follows the last plot cycle directly.
- Palette, from the latched cell code:
  - 00 -> 3'b011 (sky)
  - 01 -> 3'b010 (green)
  - 10 -> 3'b100 (red)
  - 11 -> 3'b011
- start while busy=1 is ignored. Changes on column_data or x_origin during DRAW have no effect, because the values are latched.
- x, y and colour hold their last values while plot=0.

Optional Feature:
- Macro: COLUMN_RENDERER_SKIP_EMPTY_EN.
- Defined: a cell with code 00 is not drawn.
  - On reaching px=py=0 of an empty cell, spend exactly one cycle with plot=0 and busy=1, then advance to the next cell (or to DONE if it is the last).
  - Total DRAW cycles = 64*(non-empty cells) + (empty cells) at CELL_SIZE=8.
- Undefined: every cell is drawn in full, including code 00 in sky colour.

Test Plan:
- Reset mid-render: reset low at DRAW cycle 100 -> plot=0, busy=0 and all outputs 0 in the same cycle. After release, the block idles until the next start.
- Full render at defaults: column_data=28'h0000001 (cell 0 = 01), x_origin=8'd40, start for 1 cycle ->
  - plot high for exactly 896 cycles.
  - First pixel (40,0) colour 3'b010; pixel 64 is (40,8) colour 3'b011; last pixel (47,111).
  - done=1 on the next cycle.
- Wrap: x_origin=8'd252 -> in cell 0, row 0 the x sequence is 252,253,254,255,0,1,2,3.
- Back-to-back and ignored start:
  - start held high continuously -> a second DRAW begins in the cycle after done, with no IDLE cycle.
  - A start pulse at DRAW cycle 10 has no effect.
- Data stability: column_data changed to all 10 at DRAW cycle 5 -> every colour still follows the originally latched value.
- With COLUMN_RENDERER_SKIP_EMPTY_EN:
  - column_data=0 -> 14 DRAW cycles with plot=0, then done.
  - Only cell 13 = 10 -> 13 skip cycles, then 64 plots at y=104..111 with colour 3'b100.
